// File: rtl/audio_pwm_out.sv
// audio_pwm_out: output stage after the voice mixer.
// Double-buffers the mixed sample, applies a soft-mute gain ramp and drives
// a 1-bit PWM pin (period 2^W clocks). Sample, gain and duty only change at
// the period boundary (cnt == 2^W-1) so the RC filter never sees a torn period.
// Optional build macro: AUDIO_DITHER_EN adds an LFSR dither term to the
// duty rounding; without it the scaled duty is plainly truncated.
module audio_pwm_out #(
    parameter int W         = 10,
    parameter int RAMP_DIV  = 16,
    parameter int GAIN_BITS = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_valid,
    input  logic [W-1:0]         sample_in,
    input  logic                 mute,
    output logic                 pwm_out,
    output logic                 overrun,
    output logic [GAIN_BITS-1:0] gain,
    output logic                 playing
);

    localparam logic [W-1:0]         CNT_MAX    = '1;
    localparam logic [GAIN_BITS-1:0] GAIN_UNITY = GAIN_BITS'(1 << (GAIN_BITS - 1));
    localparam int                   RW         = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RW-1:0]        RAMP_LAST  = RW'((RAMP_DIV > 1) ? RAMP_DIV - 1 : 0);
    // Wide enough for the full product plus the dither term without overflow.
    localparam int                   PW         = W + GAIN_BITS + 1;

    typedef enum logic [1:0] {
        ST_MUTED,
        ST_FADE_IN,
        ST_PLAY,
        ST_FADE_OUT
    } state_t;

    logic [W-1:0]         cnt_q, cnt_d;
    logic [W-1:0]         hold_q, hold_d;
    logic                 pending_q, pending_d;
    logic [W-1:0]         duty_q, duty_d;
    logic [RW-1:0]        ramp_q, ramp_d;
    logic [GAIN_BITS-1:0] gain_q, gain_d;
    state_t               state_q, state_d;
    logic                 pwm_q, pwm_d;
    logic                 overrun_q, overrun_d;
    logic                 playing_q, playing_d;

    logic                 boundary;
    logic [W-1:0]         src;
    logic [PW-1:0]        prod;
    logic [PW-1:0]        sum;
    logic [PW-1:0]        scaled;
    logic [W-1:0]         duty_calc;

`ifdef AUDIO_DITHER_EN
    logic [15:0]          lfsr_q, lfsr_d;

    // Galois LFSR (taps 16,14,13,11) stepping once per PWM period.
    always_comb begin
        lfsr_d = lfsr_q;
        if (boundary) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end
`endif

    // Scaled duty for the sample chosen at this boundary, saturated to full scale.
    always_comb begin
        src  = sample_valid ? sample_in : hold_q;
        prod = PW'(src) * PW'(gain_q);
`ifdef AUDIO_DITHER_EN
        sum  = prod + PW'(lfsr_q[GAIN_BITS-2:0]);
`else
        sum  = prod;
`endif
        scaled = sum >> (GAIN_BITS - 1);
        if (scaled > PW'(CNT_MAX)) begin
            duty_calc = CNT_MAX;
        end else begin
            duty_calc = scaled[W-1:0];
        end
    end

    // Next-state logic: hold buffer, boundary updates and the gain ramp FSM.
    always_comb begin
        boundary  = (cnt_q == CNT_MAX);
        cnt_d     = cnt_q + 1'b1;
        hold_d    = hold_q;
        pending_d = pending_q;
        overrun_d = 1'b0;
        duty_d    = duty_q;
        ramp_d    = ramp_q;
        gain_d    = gain_q;
        state_d   = state_q;

        if (boundary) begin
            // A strobe landing exactly here is consumed directly, never flagged.
            hold_d    = src;
            pending_d = 1'b0;
            duty_d    = duty_calc;

            // Gain steps use the pre-step gain; the new gain shows up next period.
            case (state_q)
                ST_MUTED: begin
                    gain_d = '0;
                    if (!mute) begin
                        state_d = ST_FADE_IN;
                        ramp_d  = '0;
                    end
                end
                ST_FADE_IN: begin
                    if (mute) begin
                        state_d = ST_FADE_OUT;
                        ramp_d  = '0;
                    end else if (gain_q >= GAIN_UNITY) begin
                        // Reversal right after leaving PLAY: already at unity.
                        gain_d  = GAIN_UNITY;
                        state_d = ST_PLAY;
                        ramp_d  = '0;
                    end else if (ramp_q == RAMP_LAST) begin
                        ramp_d = '0;
                        gain_d = gain_q + 1'b1;
                        if (gain_q + 1'b1 == GAIN_UNITY) begin
                            state_d = ST_PLAY;
                        end
                    end else begin
                        ramp_d = ramp_q + 1'b1;
                    end
                end
                ST_PLAY: begin
                    gain_d = GAIN_UNITY;
                    if (mute) begin
                        state_d = ST_FADE_OUT;
                        ramp_d  = '0;
                    end
                end
                ST_FADE_OUT: begin
                    if (!mute) begin
                        state_d = ST_FADE_IN;
                        ramp_d  = '0;
                    end else if (gain_q == '0) begin
                        // Reversal right after leaving MUTED: already silent.
                        state_d = ST_MUTED;
                        ramp_d  = '0;
                    end else if (ramp_q == RAMP_LAST) begin
                        ramp_d = '0;
                        gain_d = gain_q - 1'b1;
                        if (gain_q == GAIN_BITS'(1)) begin
                            state_d = ST_MUTED;
                        end
                    end else begin
                        ramp_d = ramp_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_MUTED;
                    gain_d  = '0;
                    ramp_d  = '0;
                end
            endcase
        end else if (sample_valid) begin
            hold_d    = sample_in;
            pending_d = 1'b1;
            overrun_d = pending_q;
        end

        pwm_d     = (cnt_d < duty_d);
        playing_d = (state_d == ST_PLAY);
    end

    // State registers; reset forces silence immediately, independent of clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            hold_q    <= '0;
            pending_q <= 1'b0;
            duty_q    <= '0;
            ramp_q    <= '0;
            gain_q    <= '0;
            state_q   <= ST_MUTED;
            pwm_q     <= 1'b0;
            overrun_q <= 1'b0;
            playing_q <= 1'b0;
`ifdef AUDIO_DITHER_EN
            lfsr_q    <= 16'hACE1;
`endif
        end else begin
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            duty_q    <= duty_d;
            ramp_q    <= ramp_d;
            gain_q    <= gain_d;
            state_q   <= state_d;
            pwm_q     <= pwm_d;
            overrun_q <= overrun_d;
            playing_q <= playing_d;
`ifdef AUDIO_DITHER_EN
            lfsr_q    <= lfsr_d;
`endif
        end
    end

    assign pwm_out = pwm_q;
    assign overrun = overrun_q;
    assign gain    = gain_q;
    assign playing = playing_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out. Uses a shortened configuration (W=7,
// RAMP_DIV=2) so a complete fade fits in a short run; sample values are the
// scaled equivalents of the full-size ones (64 = half scale, 127 = full).
module tb_audio_pwm_out;

    localparam int W  = 7;
    localparam int RD = 2;
    localparam int GB = 7;
    localparam int P  = 1 << W;

    logic          clk;
    logic          rst;
    logic          sample_valid;
    logic [W-1:0]  sample_in;
    logic          mute;
    logic          pwm_out;
    logic          overrun;
    logic [GB-1:0] gain;
    logic          playing;

    int errors = 0;
    int checks = 0;
    int tb_cnt;
    int highs;

    audio_pwm_out #(.W(W), .RAMP_DIV(RD), .GAIN_BITS(GB)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .mute         (mute),
        .pwm_out      (pwm_out),
        .overrun      (overrun),
        .gain         (gain),
        .playing      (playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench copy of the free-running period counter, used only for timing.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_cnt <= 0;
        else      tb_cnt <= (tb_cnt + 1) % P;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the negedge where the counter shows value c.
    task automatic goto_cnt(input int c);
        while (tb_cnt != c) @(negedge clk);
    endtask

    // Advance past n boundaries, stopping at the negedge where the counter is 0.
    task automatic wait_bound(input int n);
        repeat (n) begin
            do @(negedge clk); while (tb_cnt != 0);
        end
    endtask

    // One-cycle sample strobe starting at the current negedge.
    task automatic strobe(input int v);
        sample_valid = 1'b1;
        sample_in    = W'(v);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Count high cycles over one whole period; must start at counter 0.
    task automatic measure(output int h);
        h = 0;
        for (int i = 0; i < P; i++) begin
            if (pwm_out === 1'b1) h++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst          = 1'b0;
        mute         = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (3) @(negedge clk);
        check("rst_pwm", 32'(pwm_out), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_gain", 32'(gain), 0);
        check("rst_playing", 32'(playing), 0);
        rst = 1'b1;

        // Fade in from MUTED with a half-scale sample.
        goto_cnt(10);
        strobe(64);
        check("first_strobe_overrun", 32'(overrun), 0);
        wait_bound(1);
        check("b1_gain", 32'(gain), 0);
        check("b1_playing", 32'(playing), 0);
        wait_bound(2);
        check("b3_gain", 32'(gain), 1);
        wait_bound(2);
        check("b5_gain", 32'(gain), 2);
        wait_bound(123);
        check("b128_gain", 32'(gain), 63);
        check("b128_playing", 32'(playing), 0);
        measure(highs);
        check("duty_g63", 32'(highs), 63);
        check("b129_playing", 32'(playing), 1);
        check("b129_gain", 32'(gain), 64);
        measure(highs);
        check("duty_gain_lag", 32'(highs), 63);
        measure(highs);
        check("duty_unity_half", 32'(highs), 64);

        // Extremes of the duty range at unity gain.
        goto_cnt(20);
        strobe(0);
        wait_bound(1);
        measure(highs);
        check("duty_zero", 32'(highs), 0);
        goto_cnt(20);
        strobe(127);
        wait_bound(1);
        measure(highs);
        check("duty_full", 32'(highs), 127);

        // Two strobes in one period: second overwrites and flags overrun once.
        goto_cnt(30);
        strobe(40);
        check("ovr_first", 32'(overrun), 0);
        goto_cnt(60);
        strobe(90);
        check("ovr_second", 32'(overrun), 1);
        @(negedge clk);
        check("ovr_one_cycle", 32'(overrun), 0);
        wait_bound(1);
        measure(highs);
        check("duty_after_ovr", 32'(highs), 90);

        // Strobe coincident with the boundary bypasses the pending sample.
        goto_cnt(50);
        strobe(33);
        check("pend_overrun", 32'(overrun), 0);
        goto_cnt(P - 1);
        strobe(75);
        check("bypass_overrun", 32'(overrun), 0);
        measure(highs);
        check("duty_bypass", 32'(highs), 75);

        // Mute mid-play, reverse after ten gain steps.
        mute = 1'b1;
        wait_bound(1);
        check("fo_start_gain", 32'(gain), 64);
        check("fo_playing", 32'(playing), 0);
        wait_bound(2);
        check("fo_gain63", 32'(gain), 63);
        wait_bound(18);
        check("fo_gain54", 32'(gain), 54);
        check("fo_gain54_playing", 32'(playing), 0);
        mute = 1'b0;
        wait_bound(1);
        check("rev_gain_kept", 32'(gain), 54);
        measure(highs);
        check("duty_g54", 32'(highs), 63);
        wait_bound(1);
        check("rev_gain55", 32'(gain), 55);
        wait_bound(18);
        check("rev_gain64", 32'(gain), 64);
        check("rev_playing", 32'(playing), 1);

        // Fresh start, then asynchronous reset in the middle of a fade-in.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        goto_cnt(10);
        strobe(127);
        wait_bound(61);
        check("fi_gain30", 32'(gain), 30);
        measure(highs);
        check("duty_g29_full", 32'(highs), 57);
        goto_cnt(5);
        check("pre_rst_pwm", 32'(pwm_out), 1);
        #1 rst = 1'b0;
        #1;
        check("async_pwm", 32'(pwm_out), 0);
        check("async_gain", 32'(gain), 0);
        check("async_playing", 32'(playing), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
